mux_rr_n: RTL and testbench
===========================

// Module: mux_rr_n
// PURPOSE
//  Parametrised N:1 arbitrated, registered multiplexer. Successor to the flat 32:1 combinational mux.
//  N producer channels offer WIDTH-bit words with valid/ready. One word per cycle is selected,
//  either by fixed priority or by round-robin, and registered into a single output stage.
//  Sits between multiple request sources (e.g. pipeline stages, MMIO) and one shared consumer.
// PARAMETERS
//  N        32  number of input channels, 2..32
//  WIDTH    32  data width per channel
//  SEL_W     5  index width, $clog2(N); must be >=1
//  RR        1  1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
// PORTS
//  clock      in   1           rising-edge clock
//  reset_n    in   1           asynchronous, active-low reset
//  in_data    in   N*WIDTH     channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N           channel i has a word
//  in_ready   out  N           channel i's word is taken this cycle (one-hot or zero)
//  chan_en    in   N           channel i eligible for arbitration; masked channels never granted
//  out_data   out  WIDTH       registered selected word
//  out_idx    out  SEL_W       registered index of channel that supplied out_data
//  out_valid  out  1           out_data/out_idx hold a word
//  out_ready  in   1           consumer takes the word this cycle when out_valid=1
//  xfer_cnt   out  32          count of words accepted from inputs, wraps 2^32-1 -> 0
// BEHAVIOUR
//  Reset (reset_n=0, async): out_valid=0, out_data=0, out_idx=0, xfer_cnt=0, rr pointer=0.
//   in_ready=0 while in reset. Reset mid-transfer discards the held word; no handshake completes.
//  req[i] = in_valid[i] & chan_en[i].
//  load = ~out_valid | out_ready (output stage empty or draining this cycle).
//  Grant (combinational): g = selected index among req; none if req==0.
//   RR=0: lowest i with req[i]=1.
//   RR=1: first i with req[i]=1 searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap modulo N).
//  in_ready[i] = load & (req!=0) & (i==g). At most one bit set; zero when load=0 or req=0.
//  in_ready must not depend on in_data; may depend on in_valid, chan_en, out_valid, out_ready.
//  On clock edge with load=1:
//   req!=0 -> out_data<=in_data[g], out_idx<=g, out_valid<=1, xfer_cnt<=xfer_cnt+1,
//             RR=1: ptr <= (g==N-1) ? 0 : g+1.
//   req==0 -> out_valid<=0; out_data, out_idx, ptr hold.
//  On clock edge with load=0: all state holds (stall; out_data stable while out_valid & ~out_ready).
//  Latency: input accepted cycle k -> visible on outputs cycle k+1. Throughput 1 word/cycle
//   when out_ready held high (simultaneous drain and refill permitted).
//  ptr only advances on an accepted transfer; it never advances on stall or idle.
//  RR fairness: with all N channels continuously requesting and out_ready=1, each channel is
//   granted exactly once in every N consecutive transfers.
//  chan_en deassert while a word from that channel is already in out_data does not cancel it.
//  out_ready while out_valid=0 has no effect.
// TESTING
//  1 Static scan (N=32, RR=0, out_ready=1): only in_valid[i]=1, in_data[i]=i, for i=0..31
//    -> next cycle out_data=i, out_idx=i, out_valid=1; xfer_cnt=32 after scan.
//  2 Fixed priority: in_valid=0x0000_0014 held, RR=0, out_ready=1 -> out_idx=2 every cycle,
//    in_ready=0x0000_0004; channel 4 never granted.
//  3 Round-robin: RR=1, all in_valid=1, chan_en=all ones, out_ready=1 -> out_idx sequence
//    0,1,...,31,0,1; then chan_en[5]=0 -> index 5 skipped, sequence ...,4,6,....
//  4 Backpressure: out_valid=1 word 0xA5, out_ready=0 for 3 cycles with in_valid=all ones
//    -> in_ready=0, out_data=0xA5 stable, xfer_cnt unchanged; out_ready=1 -> refill next cycle.
//  5 Reset mid-stream: assert reset_n=0 between edges while out_valid=1 -> out_valid=0,
//    xfer_cnt=0 immediately; after release, RR grant restarts at channel 0.
//  6 Counter wrap: force xfer_cnt to 0xFFFF_FFFF via one more transfer -> xfer_cnt=0.

Source files
------------

// File: rtl/mux_rr_n.sv
// rtl/mux_rr_n.sv - N:1 arbitrated registered multiplexer with fixed-priority or round-robin grant
// SEL_W must be wide enough to index N channels.
module mux_rr_n #(
  parameter int N     = 32,
  parameter int WIDTH = 32,
  parameter int SEL_W = 5,
  parameter bit RR    = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N-1:0]       chan_en,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_idx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        xfer_cnt
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      xfer_cnt_q, xfer_cnt_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     req;
  logic             load;
  logic             grant_found;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  int               cand;

  // Search order starts at ptr for round-robin, at channel 0 for fixed priority.
  always_comb begin : arbiter
    req         = in_valid & chan_en;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      if (RR) begin
        cand = int'(ptr_q) + k;
        if (cand >= N) cand = cand - N;
      end else begin
        cand = k;
      end
      if (!grant_found && req[cand[SEL_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin : data_select
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin : next_state
    load        = ~out_valid_q | out_ready;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    ptr_d       = ptr_q;
    in_ready    = '0;
    if (load) begin
      if (grant_found) begin
        out_data_d  = grant_data;
        out_idx_d   = grant_idx;
        out_valid_d = 1'b1;
        xfer_cnt_d  = xfer_cnt_q + 32'd1;
        if (RR) begin
          if (grant_idx == SEL_W'(N-1)) ptr_d = '0;
          else                          ptr_d = grant_idx + SEL_W'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
    // Handshake is suppressed while reset is held so no word is taken.
    if (reset_n && load && grant_found) in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_rr_n.sv
// tb/tb_mux_rr_n.sv - self-checking bench for mux_rr_n, fixed-priority and round-robin instances
module tb_mux_rr_n;
  localparam int N = 32;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, chan_en;
  logic           out_ready;

  logic [N-1:0]   in_ready_fp, in_ready_rr;
  logic [W-1:0]   out_data_fp, out_data_rr;
  logic [4:0]     out_idx_fp, out_idx_rr;
  logic           out_valid_fp, out_valid_rr;
  logic [31:0]    xfer_cnt_fp, xfer_cnt_rr;

  int vectors = 0;
  int miscompares = 0;

  // Reference state, index 0 = fixed priority, 1 = round-robin.
  bit          m_valid[2];
  logic [31:0] m_data[2];
  int          m_idx[2];
  logic [31:0] m_cnt[2];
  int          order[$];

  typedef struct {
    logic [31:0] valid;
    logic [31:0] en;
    int          exp_idx;
  } vec_t;

  mux_rr_n #(.N(N), .WIDTH(W), .SEL_W(5), .RR(1'b0)) u_fp (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_fp), .chan_en(chan_en), .out_data(out_data_fp),
    .out_idx(out_idx_fp), .out_valid(out_valid_fp), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt_fp));

  mux_rr_n #(.N(N), .WIDTH(W), .SEL_W(5), .RR(1'b1)) u_rr (
    .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_rr), .chan_en(chan_en), .out_data(out_data_rr),
    .out_idx(out_idx_rr), .out_valid(out_valid_rr), .out_ready(out_ready),
    .xfer_cnt(xfer_cnt_rr));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_idx[k]   = 0;
      m_cnt[k]   = '0;
    end
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
  endtask

  // Lowest set bit of the request vector.
  function automatic int fp_grant(input logic [N-1:0] r);
    if (r == '0) return -1;
    return $clog2(r & (~r + 1'b1));
  endfunction

  // First requester in the current rotation order.
  function automatic int rr_grant(input logic [N-1:0] r);
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic check_outputs();
    chk("fp out_valid", out_valid_fp, m_valid[0]);
    chk("fp out_idx",   out_idx_fp,   m_idx[0]);
    chk("fp out_data",  out_data_fp,  m_data[0]);
    chk("fp xfer_cnt",  xfer_cnt_fp,  m_cnt[0]);
    chk("rr out_valid", out_valid_rr, m_valid[1]);
    chk("rr out_idx",   out_idx_rr,   m_idx[1]);
    chk("rr out_data",  out_data_rr,  m_data[1]);
    chk("rr xfer_cnt",  xfer_cnt_rr,  m_cnt[1]);
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic cycle(input bit force_cnt);
    int           g[2];
    bit           ld[2];
    logic [N-1:0] req, er;
    #1;
    req  = in_valid & chan_en;
    g[0] = fp_grant(req);
    g[1] = rr_grant(req);
    for (int k = 0; k < 2; k++) begin
      ld[k] = !m_valid[k] || out_ready;
      er = '0;
      if (ld[k] && g[k] >= 0) er[g[k]] = 1'b1;
      if (k == 0) chk("fp in_ready", in_ready_fp, er);
      else        chk("rr in_ready", in_ready_rr, er);
    end
    if (force_cnt) begin
      force u_fp.xfer_cnt_d = 32'hFFFF_FFFF;
      force u_rr.xfer_cnt_d = 32'hFFFF_FFFF;
    end
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      if (ld[k]) begin
        if (g[k] >= 0) begin
          m_valid[k] = 1'b1;
          m_data[k]  = in_data[g[k]*W +: W];
          m_idx[k]   = g[k];
          m_cnt[k]   = m_cnt[k] + 1;
          if (k == 1) while (order[0] != (g[k] + 1) % N) order.push_back(order.pop_front());
        end else begin
          m_valid[k] = 1'b0;
        end
      end
      if (force_cnt) m_cnt[k] = 32'hFFFF_FFFF;
    end
    #1;
    if (force_cnt) begin
      release u_fp.xfer_cnt_d;
      release u_rr.xfer_cnt_d;
    end
    check_outputs();
    @(negedge clock);
  endtask

  task automatic sync_reset_pulse();
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  vec_t tbl[$];
  int   exp_i;

  initial begin
    reset_n   = 1'b0;
    in_valid  = '1;
    chan_en   = '1;
    out_ready = 1'b1;
    in_data   = '0;
    model_reset();
    #1;
    chk("reset in_ready fp", in_ready_fp, 32'h0);
    chk("reset in_ready rr", in_ready_rr, 32'h0);
    check_outputs();
    @(negedge clock);
    reset_n  = 1'b1;
    in_valid = '0;

    // Static scan through fixed-priority instance
    sync_reset_pulse();
    for (int i = 0; i < N; i++) begin
      in_valid = 32'h1 << i;
      in_data[i*W +: W] = 32'(i);
      cycle(1'b0);
      chk("scan out_idx", out_idx_fp, i);
      chk("scan out_data", out_data_fp, i);
    end
    chk("scan xfer_cnt", xfer_cnt_fp, 32);

    // Table of fixed-priority grants
    tbl = '{
      '{32'h0000_0014, 32'hFFFF_FFFF, 2},
      '{32'h0000_0014, 32'hFFFF_FFFF, 2},
      '{32'h0000_0014, 32'hFFFF_FFFF, 2},
      '{32'h0000_0014, 32'hFFFF_FFFB, 4},
      '{32'h8000_0000, 32'hFFFF_FFFF, 31},
      '{32'h0000_0000, 32'hFFFF_FFFF, -1},
      '{32'hFFFF_FFFF, 32'h0000_0000, -1},
      '{32'h0000_00F0, 32'h0000_00A0, 5},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0}
    };
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000_0000 + 32'(i);
    out_ready = 1'b1;
    foreach (tbl[t]) begin
      in_valid = tbl[t].valid;
      chan_en  = tbl[t].en;
      cycle(1'b0);
      chk("tbl out_valid", out_valid_fp, tbl[t].exp_idx >= 0);
      chk("tbl in_ready", in_ready_fp, (tbl[t].exp_idx >= 0) ? (64'h1 << tbl[t].exp_idx) : 64'h0);
      if (tbl[t].exp_idx >= 0) begin
        chk("tbl out_idx", out_idx_fp, tbl[t].exp_idx);
        chk("tbl out_data", out_data_fp, 32'h1000_0000 + 32'(tbl[t].exp_idx));
      end
    end

    // Round-robin rotation, then channel 5 masked
    sync_reset_pulse();
    in_valid = '1;
    chan_en  = '1;
    for (int i = 0; i < N + 2; i++) begin
      cycle(1'b0);
      chk("rr seq", out_idx_rr, i % N);
    end
    chan_en[5] = 1'b0;
    exp_i = 2;
    for (int i = 0; i < 40; i++) begin
      if (exp_i == 5) exp_i = 6;
      cycle(1'b0);
      chk("rr skip5", out_idx_rr, exp_i);
      exp_i = (exp_i + 1) % N;
    end
    chan_en = '1;

    // Backpressure
    sync_reset_pulse();
    in_valid = 32'h1;
    in_data[0 +: W] = 32'hA5;
    out_ready = 1'b0;
    cycle(1'b0);
    chk("bp load", out_data_rr, 32'hA5);
    for (int i = 1; i < N; i++) in_data[i*W +: W] = 32'h100 + 32'(i);
    in_valid = '1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      chk("bp in_ready rr", in_ready_rr, 32'h0);
      chk("bp in_ready fp", in_ready_fp, 32'h0);
      chk("bp data hold", out_data_rr, 32'hA5);
      chk("bp cnt hold", xfer_cnt_rr, 1);
    end
    out_ready = 1'b1;
    cycle(1'b0);
    chk("bp refill rr idx", out_idx_rr, 1);
    chk("bp refill rr data", out_data_rr, 32'h101);
    chk("bp refill fp idx", out_idx_fp, 0);
    chk("bp refill cnt", xfer_cnt_rr, 2);

    // Asynchronous reset between edges while holding a word
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async out_valid", out_valid_rr, 1'b0);
    chk("async xfer_cnt", xfer_cnt_rr, 32'h0);
    chk("async in_ready", in_ready_rr, 32'h0);
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    cycle(1'b0);
    chk("post reset rr idx", out_idx_rr, 0);
    cycle(1'b0);
    chk("post reset rr idx2", out_idx_rr, 1);

    // Counter wrap
    in_valid = '0;
    cycle(1'b1);
    chk("wrap preset", xfer_cnt_rr, 32'hFFFF_FFFF);
    in_valid = 32'h8;
    cycle(1'b0);
    chk("wrap rr", xfer_cnt_rr, 32'h0);
    chk("wrap fp", xfer_cnt_fp, 32'h0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      case ($urandom_range(0, 3))
        0: in_valid = $urandom & $urandom & $urandom;
        1: in_valid = '1;
        default: in_valid = $urandom;
      endcase
      chan_en   = ($urandom_range(0, 1) == 0) ? '1 : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
      end else begin
        cycle(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
